mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single backing data memory (128-bit line read, 32-bit word write) between two requesters: port 0 = data-cache refill/write-through, port 1 = instruction-side line refill (read-only).
- Sits between the cache controllers and the backing memory. Serialises accesses, holds memory enables until memory signals ready, and returns line data with a one-cycle ack.
- Round-robin arbitration with a watchdog timeout so a stuck memory cannot hang the core stall logic.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, write word width
LINE_W, 128, read line width
TIMEOUT, 15, maximum cycles in ACCESS before forced error completion (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
r0_req  in  1  port 0 request; held with r0_we/r0_addr/r0_wdata stable until r0_ack
r0_we  in  1  port 0: 1 = word write, 0 = line read
r0_addr  in  ADDR_W  port 0 address
r0_wdata  in  DATA_W  port 0 write data
r0_ack  out  1  port 0 completion pulse, one cycle
r0_rdata  out  LINE_W  port 0 read line, valid when r0_ack=1
r1_req  in  1  port 1 read request; held with r1_addr stable until r1_ack
r1_addr  in  ADDR_W  port 1 address
r1_ack  out  1  port 1 completion pulse, one cycle
r1_rdata  out  LINE_W  port 1 read line, valid when r1_ack=1
err  out  1  timeout flag, valid only in the ack cycle
mem_rd_en  out  1  backing memory read enable, level
mem_wr_en  out  1  backing memory write enable, level
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  LINE_W  backing memory line
mem_ready  in  1  backing memory completion, sampled only in ACCESS
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE.
  - All outputs 0: acks, rdata, err, mem enables, mem_addr, mem_wdata, busy.
  - last_grant=1, so port 0 wins the first tie.
  - The watchdog counter clears.
  - A reset mid-access abandons the access with no ack.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any req is high at a clock edge, choose a winner: the sole requester, or on a tie the port not equal to last_grant.
  - Latch the winner's addr, wdata and we into mem_* and owner, set last_grant=owner, clear the counter, and go to ACCESS.
  - A port 1 request always latches we=0.
- ACCESS:
  - mem_rd_en = ~we and mem_wr_en = we, held continuously. Exactly one enable is high.
  - On the edge where mem_ready=1: capture mem_rdata into the owner's rdata (write access: rdata unchanged), pulse the owner's ack, set err=0, drop the enables, and go to RESP.
  - Otherwise the counter increments. On the edge where counter==TIMEOUT-1 and mem_ready=0: owner's ack=1, err=1, owner's rdata=0, enables dropped, go to RESP.
- RESP: ack/err are high for exactly this one cycle. Next state is IDLE, where they return to 0.
- Requests are not sampled during ACCESS or RESP. A req still high in the IDLE cycle after ack is a new request.
- Latency: req is first seen at edge E0, and the enables are high from E0. If mem_ready is high in cycle n after E0 (n>=0), ack is high in cycle n+1. Minimum request-to-ack is 2 cycles. Back-to-back grants are spaced at least 3 cycles apart.
- Non-owner req held high waits; round-robin guarantees service within one access of the other port.
- mem_ready high in IDLE or RESP is ignored.
- A requester dropping req before ack is a protocol violation. The arbiter still completes the access and pulses ack.

Test Plan:
- Single read: r0_req=1, r0_we=0, addr=0x01A; memory returns 0x0123..CDEF with mem_ready 2 cycles later -> mem_rd_en high 3 cycles; r0_ack pulses 1 cycle with r0_rdata=0x0123..CDEF, err=0; r1_ack stays 0.
- Write: r0_we=1, addr=0x3FF, wdata=0xDEADBEEF, mem_ready after 1 cycle -> mem_wr_en=1, mem_rd_en=0, mem_wdata=0xDEADBEEF; r0_ack pulses once; r0_rdata unchanged.
- Tie after reset: r0_req and r1_req asserted in the same cycle and held -> port 0 is served first, then port 1 once back in IDLE. A second tie after that is granted to port 0 (round-robin alternates).
- Timeout: r1_req=1, mem_ready held 0 -> enables drop after 15 ACCESS cycles; r1_ack=1, err=1, r1_rdata=0 in one cycle; FSM returns to IDLE.
- Reset mid-access: assert RST=0 two cycles into ACCESS -> enables, acks and busy drop immediately (asynchronous). After release, a port-0/port-1 tie grants port 0.
- Stray ready: mem_ready=1 while IDLE with no req -> no ack, no state change, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the backing data memory.
// Serialises line reads / word writes and force-completes stuck accesses via a watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [LINE_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_ack,
  output logic [LINE_W-1:0] r1_rdata,
  output logic              err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant1;

  logic              r0_ack_d, r1_ack_d, err_d, busy_d;
  logic              mem_rd_en_d, mem_wr_en_d;
  logic [LINE_W-1:0] r0_rdata_d, r1_rdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      r0_ack       <= r0_ack_d;
      r1_ack       <= r1_ack_d;
      err          <= err_d;
      busy         <= busy_d;
      mem_rd_en    <= mem_rd_en_d;
      mem_wr_en    <= mem_wr_en_d;
      r0_rdata     <= r0_rdata_d;
      r1_rdata     <= r1_rdata_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    grant1       = 1'b0;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    err_d        = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_wr_en_d  = 1'b0;
    r0_rdata_d   = r0_rdata;
    r1_rdata_d   = r1_rdata;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // Port 1 wins when alone, or on a tie when port 0 was granted last
          grant1       = r1_req && (!r0_req || !last_grant_q);
          owner_d      = grant1;
          we_d         = grant1 ? 1'b0 : r0_we;
          mem_addr_d   = grant1 ? r1_addr : r0_addr;
          mem_wdata_d  = grant1 ? '0 : r0_wdata;
          last_grant_d = grant1;
          cnt_d        = '0;
          mem_rd_en_d  = !we_d;
          mem_wr_en_d  = we_d;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          r0_ack_d = !owner_q;
          r1_ack_d = owner_q;
          if (!we_q) begin
            if (owner_q) r1_rdata_d = mem_rdata;
            else         r0_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          r0_ack_d = !owner_q;
          r1_ack_d = owner_q;
          err_d    = 1'b1;
          if (owner_q) r1_rdata_d = '0;
          else         r0_rdata_d = '0;
          state_d  = S_RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mem_rd_en_d = !we_q;
          mem_wr_en_d = we_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter against a transaction-level model
// (round-robin winner, latency = min(ready delay, TIMEOUT-1) + 1, per-port returned line).
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              RST;
  logic              r0_req, r0_we, r1_req;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack, r1_ack, err, busy;
  logic [LINE_W-1:0] r0_rdata, r1_rdata;
  logic              mem_rd_en, mem_wr_en, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .RST(RST),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .err(err), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;
  bit                model_last;
  logic [LINE_W-1:0] exp_rdata [2];

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
    return int'($urandom_range(0, 4));
  endfunction

  // Serve one grant to 'port' with memory answering after d ACCESS cycles.
  // Entered at a negedge of an IDLE cycle with the requests already driven.
  task automatic serve(input bit port, input int d, input logic [LINE_W-1:0] line);
    bit                we;
    bit                to;
    int                kend;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    we   = port ? 1'b0 : r0_we;
    a    = port ? r1_addr : r0_addr;
    wd   = r0_wdata;
    to   = (d >= int'(TIMEOUT));
    kend = to ? int'(TIMEOUT) - 1 : d;
    mem_rdata = line;
    for (int k = 0; k <= kend + 1; k++) begin
      @(negedge clk);
      if (k <= kend) begin
        check("access_busy", LINE_W'(busy), LINE_W'(1'b1));
        check("access_rd_en", LINE_W'(mem_rd_en), LINE_W'(!we));
        check("access_wr_en", LINE_W'(mem_wr_en), LINE_W'(we));
        check("access_r0_ack", LINE_W'(r0_ack), '0);
        check("access_r1_ack", LINE_W'(r1_ack), '0);
        check("access_addr", LINE_W'(mem_addr), LINE_W'(a));
        if (we) check("access_wdata", LINE_W'(mem_wdata), LINE_W'(wd));
        mem_ready = (k == d);
      end else begin
        if (to)       exp_rdata[port] = '0;
        else if (!we) exp_rdata[port] = line;
        check("resp_busy", LINE_W'(busy), LINE_W'(1'b1));
        check("resp_rd_en", LINE_W'(mem_rd_en), '0);
        check("resp_wr_en", LINE_W'(mem_wr_en), '0);
        check("resp_r0_ack", LINE_W'(r0_ack), LINE_W'(!port));
        check("resp_r1_ack", LINE_W'(r1_ack), LINE_W'(port));
        check("resp_err", LINE_W'(err), LINE_W'(to));
        check("resp_r0_rdata", r0_rdata, exp_rdata[0]);
        check("resp_r1_rdata", r1_rdata, exp_rdata[1]);
        if (port) r1_req = 1'b0;
        else      r0_req = 1'b0;
        mem_ready = 1'($urandom);
      end
    end
    @(negedge clk);
    check("idle_busy", LINE_W'(busy), '0);
    check("idle_r0_ack", LINE_W'(r0_ack), '0);
    check("idle_r1_ack", LINE_W'(r1_ack), '0);
    check("idle_err", LINE_W'(err), '0);
    mem_ready = 1'b0;
  endtask

  // Drive both requests together and serve them in round-robin order.
  task automatic tie(input bit exp_first);
    r0_req = 1'b1;
    r1_req = 1'b1;
    check("tie_winner_model", LINE_W'(!model_last), LINE_W'(exp_first));
    model_last = !model_last;
    serve(model_last, rand_delay(), rand_line());
    model_last = !model_last;
    serve(model_last, rand_delay(), rand_line());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, n_errors %0d", n_errors);
    $fatal(1);
  end

  initial begin
    logic [2:0] sel;
    bit         win;
    RST = 1'b0; r0_req = 1'b0; r0_we = 1'b0; r1_req = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    #12;
    check("rst_busy", LINE_W'(busy), '0);
    check("rst_rd_en", LINE_W'(mem_rd_en), '0);
    check("rst_wr_en", LINE_W'(mem_wr_en), '0);
    check("rst_acks", LINE_W'({r0_ack, r1_ack, err}), '0);
    check("rst_r0_rdata", r0_rdata, '0);
    check("rst_mem_addr", LINE_W'(mem_addr), '0);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);

    // Tie straight after reset goes to port 0, and round-robin returns to port 0 next time
    tie(1'b0);
    tie(1'b0);

    // Single line read
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h01A;
    model_last = 1'b0;
    serve(1'b0, 2, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Word write leaves the returned line untouched
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h3FF; r0_wdata = 32'hDEADBEEF;
    model_last = 1'b0;
    serve(1'b0, 1, rand_line());

    // Ready exactly on the last watchdog cycle still completes cleanly
    r1_req = 1'b1; r1_addr = 10'h155;
    model_last = 1'b1;
    serve(1'b1, int'(TIMEOUT) - 1, rand_line());

    // Watchdog timeout on port 1
    r1_req = 1'b1; r1_addr = 10'h2AA;
    model_last = 1'b1;
    serve(1'b1, int'(TIMEOUT) + 5, rand_line());

    // Stray ready in IDLE with no request
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_busy", LINE_W'(busy), '0);
      check("stray_acks", LINE_W'({r0_ack, r1_ack, err}), '0);
      check("stray_r0_rdata", r0_rdata, exp_rdata[0]);
      check("stray_r1_rdata", r1_rdata, exp_rdata[1]);
    end
    mem_ready = 1'b0;

    // Reset two cycles into an access
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h0F0;
    @(negedge clk);
    @(negedge clk);
    #1 RST = 1'b0;
    #1;
    check("midrst_busy", LINE_W'(busy), '0);
    check("midrst_rd_en", LINE_W'(mem_rd_en), '0);
    check("midrst_acks", LINE_W'({r0_ack, r1_ack}), '0);
    check("midrst_addr", LINE_W'(mem_addr), '0);
    r0_req = 1'b0;
    model_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("midrst_r0_rdata", r0_rdata, '0);
    tie(1'b0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      sel      = 3'($urandom_range(1, 3));
      r0_we    = 1'($urandom);
      r0_addr  = ADDR_W'($urandom);
      r0_wdata = DATA_W'($urandom);
      r1_addr  = ADDR_W'($urandom);
      r0_req   = sel[0];
      r1_req   = sel[1];
      win        = (sel == 3'd3) ? !model_last : sel[1];
      model_last = win;
      serve(win, rand_delay(), rand_line());
      if (sel == 3'd3) begin
        model_last = !win;
        serve(!win, rand_delay(), rand_line());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
